// File: rtl/phy_rx.sv
// Receive-side lane distributor: aligns a byte stream on COM and deinterleaves
// it round-robin into four 8-bit lanes, with lock tracking and an error counter.
module phy_rx #(
   parameter logic [7:0] COM_SYMBOL = 8'hBC,
   parameter int         IDLE_LIMIT = 16,
   parameter int         ERR_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           data_in,
   input  logic                 valid_in,
   output logic [7:0]           data_out0,
   output logic [7:0]           data_out1,
   output logic [7:0]           data_out2,
   output logic [7:0]           data_out3,
   output logic                 valid_out,
   output logic                 locked,
   output logic [ERR_WIDTH-1:0] err_count
);

   typedef enum logic [0:0] {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam logic [7:0]           IDLE_LAST = 8'(IDLE_LIMIT - 1);
   localparam logic [ERR_WIDTH-1:0] ERR_MAX   = {ERR_WIDTH{1'b1}};

   state_t               r_state;
   logic [1:0]           r_cnt;
   logic [7:0]           r_idle;
   logic [7:0]           r_lane0;
   logic [7:0]           r_lane1;
   logic [7:0]           r_lane2;
   logic [7:0]           r_dout0;
   logic [7:0]           r_dout1;
   logic [7:0]           r_dout2;
   logic [7:0]           r_dout3;
   logic                 r_valid_out;
   logic                 r_locked;
   logic [ERR_WIDTH-1:0] r_err;

   logic                 w_is_com;

   // Payload never carries COM, so any valid COM byte is an alignment marker.
   always_comb begin
      w_is_com = 1'b0;
      if (valid_in && (data_in == COM_SYMBOL)) begin
         w_is_com = 1'b1;
      end else begin
         w_is_com = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_HUNT;
         r_cnt       <= 2'd0;
         r_idle      <= 8'd0;
         r_lane0     <= 8'd0;
         r_lane1     <= 8'd0;
         r_lane2     <= 8'd0;
         r_dout0     <= 8'd0;
         r_dout1     <= 8'd0;
         r_dout2     <= 8'd0;
         r_dout3     <= 8'd0;
         r_valid_out <= 1'b0;
         r_locked    <= 1'b0;
         r_err       <= {ERR_WIDTH{1'b0}};
      end else begin
         r_valid_out <= 1'b0;
         case (r_state)
            ST_HUNT: begin
               if (w_is_com) begin
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
                  r_cnt    <= 2'd0;
                  r_idle   <= 8'd0;
               end else begin
                  r_locked <= 1'b0;
               end
            end
            ST_LOCKED: begin
               if (!valid_in) begin
                  // Idle timeout drops lock silently; partial group is thrown away.
                  if (r_idle == IDLE_LAST) begin
                     r_state  <= ST_HUNT;
                     r_locked <= 1'b0;
                     r_cnt    <= 2'd0;
                     r_idle   <= 8'd0;
                     r_lane0  <= 8'd0;
                     r_lane1  <= 8'd0;
                     r_lane2  <= 8'd0;
                  end else begin
                     r_idle <= r_idle + 8'd1;
                  end
               end else if (w_is_com) begin
                  r_idle <= 8'd0;
                  if (r_cnt != 2'd0) begin
                     r_cnt   <= 2'd0;
                     r_lane0 <= 8'd0;
                     r_lane1 <= 8'd0;
                     r_lane2 <= 8'd0;
                     if (r_err != ERR_MAX) begin
                        r_err <= r_err + {{(ERR_WIDTH-1){1'b0}}, 1'b1};
                     end else begin
                        r_err <= r_err;
                     end
                  end else begin
                     r_cnt <= 2'd0;
                  end
               end else begin
                  r_idle <= 8'd0;
                  r_cnt  <= r_cnt + 2'd1;
                  case (r_cnt)
                     2'd0: r_lane0 <= data_in;
                     2'd1: r_lane1 <= data_in;
                     2'd2: r_lane2 <= data_in;
                     2'd3: begin
                        r_dout0     <= r_lane0;
                        r_dout1     <= r_lane1;
                        r_dout2     <= r_lane2;
                        r_dout3     <= data_in;
                        r_valid_out <= 1'b1;
                     end
                     default: r_cnt <= 2'd0;
                  endcase
               end
            end
            default: begin
               r_state  <= ST_HUNT;
               r_locked <= 1'b0;
               r_cnt    <= 2'd0;
               r_idle   <= 8'd0;
            end
         endcase
      end
   end

   assign data_out0 = r_dout0;
   assign data_out1 = r_dout1;
   assign data_out2 = r_dout2;
   assign data_out3 = r_dout3;
   assign valid_out = r_valid_out;
   assign locked    = r_locked;
   assign err_count = r_err;

endmodule

// File: tb/tb_phy_rx.sv
// Scoreboard bench for phy_rx: directed byte streams push expected groups,
// a negedge monitor pops and compares every valid_out pulse.
module tb_phy_rx;

   logic       clk;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic [7:0] data_out0;
   logic [7:0] data_out1;
   logic [7:0] data_out2;
   logic [7:0] data_out3;
   logic       valid_out;
   logic       locked;
   logic [7:0] err_count;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   phy_rx #(.COM_SYMBOL(8'hBC), .IDLE_LIMIT(16), .ERR_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
      .data_out3(data_out3), .valid_out(valid_out), .locked(locked),
      .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock with the given byte presented; returns 1 time unit past the edge.
   task automatic cyc(input logic v, input logic [7:0] d);
      valid_in = v;
      data_in  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
   endtask

   // Monitor: every valid_out pulse must match the oldest expected group.
   always @(negedge clk) begin
      if (!reset && valid_out) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_group: got %h%h%h%h expected none",
                     data_out0, data_out1, data_out2, data_out3);
         end else begin
            chk("group", {data_out0, data_out1, data_out2, data_out3}, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {data_out0, data_out1, data_out2, data_out3, 6'd0, valid_out, locked},
          {32'h0, 8'h00});
      chk("reset_err", {24'd0, err_count}, 32'd0);
      #2 reset = 1'b0;
      idle(2);

      // Hunt, lock and two back-to-back groups
      cyc(1'b1, 8'h11);
      cyc(1'b1, 8'h22);
      chk("hunt_unlocked", {31'd0, locked}, 32'd0);
      cyc(1'b1, 8'hBC);
      chk("lock_after_com", {31'd0, locked}, 32'd1);
      exp_q.push_back(32'h01020304);
      exp_q.push_back(32'h05060708);
      for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i));
      idle(2);

      // Asynchronous reset mid-group, checked before any clock edge
      cyc(1'b1, 8'h09);
      cyc(1'b1, 8'h0A);
      valid_in = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async_reset_data", {data_out0, data_out1, data_out2, data_out3}, 32'h0);
      chk("async_reset_flags", {22'd0, err_count, valid_out, locked}, 32'd0);
      #3 reset = 1'b0;
      idle(2);
      cyc(1'b1, 8'hBC);
      chk("relock", {31'd0, locked}, 32'd1);

      // Gapped group
      exp_q.push_back(32'h31323334);
      cyc(1'b1, 8'h31); idle(3);
      cyc(1'b1, 8'h32); idle(3);
      cyc(1'b1, 8'h33); idle(3);
      cyc(1'b1, 8'h34); idle(2);
      chk("gap_err", {24'd0, err_count}, 32'd0);
      chk("gap_locked", {31'd0, locked}, 32'd1);

      // Misaligned COM discards A1/A2
      cyc(1'b1, 8'hA1);
      cyc(1'b1, 8'hA2);
      cyc(1'b1, 8'hBC);
      chk("misalign_err", {24'd0, err_count}, 32'd1);
      exp_q.push_back(32'hB1B2B3B4);
      for (int i = 1; i <= 4; i++) cyc(1'b1, 8'hB0 + 8'(i));
      cyc(1'b1, 8'hBC);
      chk("skip_com_err", {24'd0, err_count}, 32'd1);
      chk("skip_com_locked", {31'd0, locked}, 32'd1);

      // Idle timeout at cnt=2
      cyc(1'b1, 8'h61);
      cyc(1'b1, 8'h62);
      idle(15);
      chk("idle15_locked", {31'd0, locked}, 32'd1);
      idle(1);
      chk("idle16_unlocked", {31'd0, locked}, 32'd0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h55);
      chk("hunt_no_lock", {31'd0, locked}, 32'd0);
      cyc(1'b1, 8'hBC);
      chk("relock2", {31'd0, locked}, 32'd1);
      chk("timeout_no_err", {24'd0, err_count}, 32'd1);
      exp_q.push_back(32'h71727374);
      for (int i = 1; i <= 4; i++) cyc(1'b1, 8'h70 + 8'(i));
      idle(2);
      chk("hold_after_group", {data_out0, data_out1, data_out2, data_out3}, 32'h71727374);

      // Error counter saturation
      for (int i = 0; i < 260; i++) begin
         cyc(1'b1, 8'h01);
         cyc(1'b1, 8'hBC);
         if (i == 99) chk("err_mid", {24'd0, err_count}, 32'd101);
      end
      chk("err_saturated", {24'd0, err_count}, 32'd255);
      idle(3);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
